// File: rtl/int_reg_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// RV32Consts
// Shared integer-register types for the write-back arbiter:
//   IntReg  - 32-bit register value
//   RegAddr - 5-bit register index
//   LoadRet - one buffered load return (destination + data)
//   WbState - arbiter FSM state
// ---------------------------------------------------------------------------
package RV32Consts;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef logic [XLEN-1:0] IntReg;
    typedef logic [4:0]      RegAddr;

    typedef struct packed {
        RegAddr addr;
        IntReg  data;
    } LoadRet;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } WbState;

    // Register x0 is hard-wired to zero; writes to it are discarded.
    function automatic logic is_x0(input RegAddr a);
        return (a == '0);
    endfunction

endpackage

// File: rtl/int_reg_wb_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// int_reg_wb_arbiter_wb_fifo
// Small synchronous FIFO of LoadRet entries for buffered load returns.
// The head is presented from stored state only (no fall-through), so an
// entry pushed at an edge becomes visible in the following cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (empties FIFO)
//   push_en, push_data write one entry (caller guarantees !full)
//   pop_en             remove head entry (caller guarantees !empty)
//   head               current head entry
//   full, empty        occupancy flags from registered pointers
// ---------------------------------------------------------------------------
module int_reg_wb_arbiter_wb_fifo
    import RV32Consts::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_en,
    input  LoadRet push_data,
    input  logic   pop_en,
    output LoadRet head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    LoadRet      mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push_en |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop_en |-> !empty);

endmodule

// File: rtl/int_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// int_reg_wb_arbiter
// Shares the integer register file's single write port between the execute
// path (same-cycle, combinational) and buffered load returns, and keeps a
// scoreboard of registers with outstanding loads.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   exe_wr_en/exe_rd_addr/_data     execute-path write request
//   exe_stall                       core must hold; exe write not performed
//   lsu_valid/lsu_ready/_addr/_data load-return handshake into the FIFO
//   iss_en/iss_rd_addr              load issue, marks destination busy
//   rs1_addr/rs2_addr -> rs*_busy   hazard lookup on decode read addresses
//   busy_mask                       full scoreboard (bit 0 always 0)
//   rd_en/rd_addr/rd_data           register file write port
// ---------------------------------------------------------------------------
module int_reg_wb_arbiter
    import RV32Consts::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_wr_en,
    input  logic [4:0]  exe_rd_addr,
    input  IntReg       exe_rd_data,
    output logic        exe_stall,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd_addr,
    input  IntReg       lsu_rd_data,
    input  logic        iss_en,
    input  logic [4:0]  iss_rd_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [31:0] busy_mask,
    output logic        rd_en,
    output logic [4:0]  rd_addr,
    output IntReg       rd_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    WbState             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [31:0]        busy_q, busy_d;

    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    LoadRet fifo_head;
    LoadRet lsu_ret;

    // ---------------------------------------------------------------------
    // Load-return buffer. Ready depends only on stored occupancy, so a pop
    // in the same cycle never opens the door for a push while full.
    // ---------------------------------------------------------------------
    assign lsu_ready     = !fifo_full;
    assign fifo_push     = lsu_valid && lsu_ready;
    assign lsu_ret.addr  = lsu_rd_addr;
    assign lsu_ret.data  = lsu_rd_data;

    int_reg_wb_arbiter_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (fifo_push),
        .push_data (lsu_ret),
        .pop_en    (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------------------------------------------------------------
    // Arbitration FSM and write-port mux
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        fifo_pop  = 1'b0;
        exe_stall = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;

        unique case (state_q)
            NORMAL: begin
                if (exe_wr_en) begin
                    rd_en   = !is_x0(exe_rd_addr);
                    rd_addr = exe_rd_addr;
                    rd_data = exe_rd_data;
                    if (!fifo_empty) begin
                        // Head lost this cycle; escalate once the limit is hit.
                        starve_d = starve_q + CNT_ONE;
                        if (starve_d >= CNT_LIMIT) state_d = FORCE;
                    end else begin
                        starve_d = '0;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rd_en    = !is_x0(fifo_head.addr);
                    rd_addr  = fifo_head.addr;
                    rd_data  = fifo_head.data;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end
            FORCE: begin
                // FORCE is only entered with a non-empty FIFO and nothing
                // else pops, so the head is always valid here.
                exe_stall = 1'b1;
                fifo_pop  = !fifo_empty;
                rd_en     = !fifo_empty && !is_x0(fifo_head.addr);
                rd_addr   = fifo_head.addr;
                rd_data   = fifo_head.data;
                starve_d  = '0;
                state_d   = NORMAL;
            end
            default: begin
                state_d  = NORMAL;
                starve_d = '0;
            end
        endcase

        // The write port must be quiet while reset is held, even though
        // the execute inputs are combinational.
        if (!rst_n) begin
            rd_en   = 1'b0;
            rd_addr = '0;
            rd_data = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard: clear on pop, then set on issue so a same-address
    // re-issue in the pop cycle keeps the bit set.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.addr] = 1'b0;
        if (iss_en && !is_x0(iss_rd_addr)) busy_d[iss_rd_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_mask = busy_q;
    assign rs1_busy  = busy_q[rs1_addr];
    assign rs2_busy  = busy_q[rs2_addr];

    // ---------------------------------------------------------------------
    // Obligations on the surrounding pipeline
    // ---------------------------------------------------------------------
    a_iss_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (iss_en && !is_x0(iss_rd_addr)) |->
            (!busy_q[iss_rd_addr] || (fifo_pop && fifo_head.addr == iss_rd_addr)));
    a_exe_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (exe_wr_en && !exe_stall && !is_x0(exe_rd_addr)) |-> !busy_q[exe_rd_addr]);
    a_ret_is_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_push && !is_x0(lsu_rd_addr)) |-> busy_q[lsu_rd_addr]);

endmodule

// File: tb/tb_int_reg_wb_arbiter.sv
module tb_int_reg_wb_arbiter;
    import RV32Consts::*;

    logic        clk;
    logic        rst_n;
    logic        exe_wr_en;
    logic [4:0]  exe_rd_addr;
    IntReg       exe_rd_data;
    logic        exe_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_addr;
    IntReg       lsu_rd_data;
    logic        iss_en;
    logic [4:0]  iss_rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_mask;
    logic        rd_en;
    logic [4:0]  rd_addr;
    IntReg       rd_data;

    int tests;
    int fails;

    int_reg_wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exe_wr_en   (exe_wr_en),
        .exe_rd_addr (exe_rd_addr),
        .exe_rd_data (exe_rd_data),
        .exe_stall   (exe_stall),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd_addr (lsu_rd_addr),
        .lsu_rd_data (lsu_rd_data),
        .iss_en      (iss_en),
        .iss_rd_addr (iss_rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy_mask   (busy_mask),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exe_wr_en   = 1'b0;
        exe_rd_addr = '0;
        exe_rd_data = '0;
        lsu_valid   = 1'b0;
        lsu_rd_addr = '0;
        lsu_rd_data = '0;
        iss_en      = 1'b0;
        iss_rd_addr = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();

        // ---------------- reset state (exe request held during reset) -----
        exe_wr_en   = 1'b1;
        exe_rd_addr = 5'd6;
        exe_rd_data = 32'h1111_2222;
        next_cycle();
        #1;
        chk("rst_rd_en",     {31'd0, rd_en},     32'd0);
        chk("rst_rd_addr",   {27'd0, rd_addr},   32'd0);
        chk("rst_rd_data",   rd_data,            32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_exe_stall", {31'd0, exe_stall}, 32'd0);
        chk("rst_busy_mask", busy_mask,          32'd0);
        $display("[TB] reset: rd_en=%0b lsu_ready=%0b busy=%08h", rd_en, lsu_ready, busy_mask);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;

        // ---------------- table: exe path with empty FIFO -----------------
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  1'b1, 5'd5,  32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hCAFE_F00D, 5'd0,  1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b0, 5'd9,  32'h0BAD_0BAD, 5'd9,  1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            exe_wr_en   = vecs[i].wr;
            exe_rd_addr = vecs[i].addr;
            exe_rd_data = vecs[i].data;
            rs1_addr    = vecs[i].rs1;
            #1;
            chk("vec_rd_en", {31'd0, rd_en}, {31'd0, vecs[i].exp_en});
            if (vecs[i].exp_en) begin
                chk("vec_rd_addr", {27'd0, rd_addr}, {27'd0, vecs[i].exp_addr});
                chk("vec_rd_data", rd_data, vecs[i].exp_data);
            end
            chk("vec_stall", {31'd0, exe_stall}, 32'd0);
            chk("vec_rs1_busy", {31'd0, rs1_busy}, 32'd0);
            chk("vec_busy", busy_mask, 32'd0);
            $display("[TB] vec %0d: wr=%0b addr=%0d -> rd_en=%0b rd_addr=%0d rd_data=%08h",
                     i, vecs[i].wr, vecs[i].addr, rd_en, rd_addr, rd_data);
        end
        next_cycle();
        idle_inputs();

        // ---------------- load round trip on x7 ---------------------------
        iss_en = 1'b1; iss_rd_addr = 5'd7;
        next_cycle();
        iss_en = 1'b0; rs1_addr = 5'd7;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd7; lsu_rd_data = 32'h1234_5678;
        #1;
        chk("rt_busy_set",  busy_mask,          32'h0000_0080);
        chk("rt_rs1_busy",  {31'd0, rs1_busy},  32'd1);
        chk("rt_ready",     {31'd0, lsu_ready}, 32'd1);
        chk("rt_no_fallthru", {31'd0, rd_en},   32'd0);
        next_cycle();
        lsu_valid = 1'b0;
        #1;
        chk("rt_wr_en",   {31'd0, rd_en},   32'd1);
        chk("rt_wr_addr", {27'd0, rd_addr}, 32'd7);
        chk("rt_wr_data", rd_data,          32'h1234_5678);
        chk("rt_busy_held", busy_mask,      32'h0000_0080);
        $display("[TB] load x7: write rd_en=%0b data=%08h", rd_en, rd_data);
        next_cycle();
        #1;
        chk("rt_busy_clr", busy_mask,       32'd0);
        chk("rt_rs1_clr",  {31'd0, rs1_busy}, 32'd0);
        chk("rt_idle",     {31'd0, rd_en},  32'd0);
        idle_inputs();

        // ---------------- starvation: 4 exe writes, then FORCE -----------
        next_cycle();
        iss_en = 1'b1; iss_rd_addr = 5'd3;
        next_cycle();
        iss_en = 1'b0;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd3; lsu_rd_data = 32'hA5A5_A5A5;
        exe_wr_en = 1'b1; exe_rd_addr = 5'd10; exe_rd_data = 32'h0000_0100;
        next_cycle();
        lsu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exe_rd_data = 32'h0000_0100 + i;
            #1;
            chk("sv_exe_en",    {31'd0, rd_en},     32'd1);
            chk("sv_exe_addr",  {27'd0, rd_addr},   32'd10);
            chk("sv_exe_data",  rd_data,            32'h0000_0100 + i);
            chk("sv_no_stall",  {31'd0, exe_stall}, 32'd0);
            $display("[TB] starve %0d: exe write addr=%0d data=%08h", i, rd_addr, rd_data);
            next_cycle();
        end
        exe_rd_data = 32'h0000_0200;
        #1;
        chk("sv_force_stall", {31'd0, exe_stall}, 32'd1);
        chk("sv_force_en",    {31'd0, rd_en},     32'd1);
        chk("sv_force_addr",  {27'd0, rd_addr},   32'd3);
        chk("sv_force_data",  rd_data,            32'hA5A5_A5A5);
        $display("[TB] force: stall=%0b addr=%0d data=%08h", exe_stall, rd_addr, rd_data);
        next_cycle();
        #1;
        chk("sv_resume_stall", {31'd0, exe_stall}, 32'd0);
        chk("sv_resume_addr",  {27'd0, rd_addr},   32'd10);
        chk("sv_resume_busy",  busy_mask,          32'd0);
        idle_inputs();

        // ---------------- full FIFO ---------------------------------------
        next_cycle();
        iss_en = 1'b1; iss_rd_addr = 5'd11;
        next_cycle();
        iss_rd_addr = 5'd12;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd11; lsu_rd_data = 32'h0000_0B0B;
        exe_wr_en = 1'b1; exe_rd_addr = 5'd20; exe_rd_data = 32'h0000_2000;
        next_cycle();
        iss_en = 1'b0;
        lsu_rd_addr = 5'd12; lsu_rd_data = 32'h0000_0C0C;
        #1;
        chk("full_ready_1", {31'd0, lsu_ready}, 32'd1);
        next_cycle();
        lsu_rd_addr = 5'd13; lsu_rd_data = 32'h0000_0D0D;
        #1;
        chk("full_ready_0", {31'd0, lsu_ready}, 32'd0);
        chk("full_busy",    busy_mask,          32'h0000_1800);
        $display("[TB] full: lsu_ready=%0b busy=%08h", lsu_ready, busy_mask);
        next_cycle();
        exe_wr_en = 1'b0; lsu_valid = 1'b0;
        #1;
        chk("full_pop_addr",   {27'd0, rd_addr},   32'd11);
        chk("full_pop_data",   rd_data,            32'h0000_0B0B);
        chk("full_pop_ready",  {31'd0, lsu_ready}, 32'd0);
        next_cycle();
        #1;
        chk("full_after_ready", {31'd0, lsu_ready}, 32'd1);
        chk("full_pop2_en",     {31'd0, rd_en},     32'd1);
        chk("full_pop2_addr",   {27'd0, rd_addr},   32'd12);
        next_cycle();
        #1;
        chk("full_drained", {31'd0, rd_en}, 32'd0);
        chk("full_busy_clr", busy_mask,     32'd0);
        idle_inputs();

        // ---------------- x0 discard and same-cycle set/clear -------------
        next_cycle();
        iss_en = 1'b1; iss_rd_addr = 5'd9;
        next_cycle();
        iss_en = 1'b0;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd0; lsu_rd_data = 32'h5555_5555;
        next_cycle();
        lsu_rd_addr = 5'd9; lsu_rd_data = 32'h0000_0099;
        #1;
        chk("x0_discard", {31'd0, rd_en}, 32'd0);
        $display("[TB] x0 return: rd_en=%0b", rd_en);
        next_cycle();
        lsu_valid = 1'b0;
        iss_en = 1'b1; iss_rd_addr = 5'd9;
        #1;
        chk("sc_pop_en",   {31'd0, rd_en},   32'd1);
        chk("sc_pop_addr", {27'd0, rd_addr}, 32'd9);
        chk("sc_pop_data", rd_data,          32'h0000_0099);
        next_cycle();
        iss_en = 1'b0;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd9; lsu_rd_data = 32'h0000_0077;
        #1;
        chk("sc_set_wins", busy_mask, 32'h0000_0200);
        $display("[TB] set/clear x9: busy=%08h", busy_mask);
        next_cycle();
        lsu_valid = 1'b0;
        next_cycle();
        #1;
        chk("sc_busy_clr", busy_mask, 32'd0);
        idle_inputs();

        // ---------------- reset mid-operation -----------------------------
        next_cycle();
        iss_en = 1'b1; iss_rd_addr = 5'd14;
        next_cycle();
        iss_rd_addr = 5'd15;
        lsu_valid = 1'b1; lsu_rd_addr = 5'd14; lsu_rd_data = 32'h0000_1414;
        exe_wr_en = 1'b1; exe_rd_addr = 5'd21; exe_rd_data = 32'h0000_2121;
        next_cycle();
        iss_en = 1'b0;
        lsu_rd_addr = 5'd15; lsu_rd_data = 32'h0000_1515;
        next_cycle();
        lsu_valid = 1'b0;
        rs1_addr = 5'd14; rs2_addr = 5'd15;
        #1;
        chk("mid_full",     {31'd0, lsu_ready}, 32'd0);
        chk("mid_busy",     busy_mask,          32'h0000_C000);
        chk("mid_rs2_busy", {31'd0, rs2_busy},  32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en",  {31'd0, rd_en},     32'd0);
        chk("mid_rst_busy",   busy_mask,          32'd0);
        chk("mid_rst_ready",  {31'd0, lsu_ready}, 32'd1);
        chk("mid_rst_rs1",    {31'd0, rs1_busy},  32'd0);
        $display("[TB] mid reset: rd_en=%0b busy=%08h ready=%0b", rd_en, busy_mask, lsu_ready);
        next_cycle();
        rst_n = 1'b1;
        exe_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_no_wr", {31'd0, rd_en},     32'd0);
            chk("post_rst_ready", {31'd0, lsu_ready}, 32'd1);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_reg_wb_arbiter.md
# int_reg_wb_arbiter

Write-back arbiter and load scoreboard for the integer register file. It shares the register file's single write port between the execute path, which writes in the same cycle, and the load-return channel, which is asynchronous and handshaked. Load returns are buffered in a small FIFO. The block tracks registers with outstanding loads and reports hazards on the read addresses. It sits between the core pipeline/LSU and the register file's rd_* inputs.

## Interface
- FIFO_DEPTH, 2: load-return FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO head may lose arbitration before a forced grant; ≥1.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- exe_wr_en  in  1  execute-path write request
- exe_rd_addr  in  5  execute destination
- exe_rd_data  in  RV32Consts::IntReg  execute result
- exe_stall  out  1  core must hold the current instruction; exe write not performed
- lsu_valid  in  1  load return valid
- lsu_ready  out  1  FIFO can accept
- lsu_rd_addr  in  5  load destination
- lsu_rd_data  in  RV32Consts::IntReg  load data
- iss_en  in  1  load issued this cycle
- iss_rd_addr  in  5  issued load destination
- rs1_addr, rs2_addr  in  5 each  read addresses being decoded
- rs1_busy, rs2_busy  out  1 each  addressed register has an outstanding load
- busy_mask  out  32  scoreboard; bit 0 always 0
- rd_en  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_data  out  RV32Consts::IntReg  register file write data

## Operation
- **FIFO push:** occurs on lsu_valid && lsu_ready. lsu_ready = !full, registered-state based only (no dependence on lsu_valid).
- **FSM states:** NORMAL, FORCE.
- **NORMAL:**
  - If exe_wr_en: exe wins. rd_* = exe_* and the FIFO holds.
  - Else if the FIFO is non-empty: head written, then popped.
  - exe_stall = 0.
- **Starvation counter:** increments when the FIFO is non-empty and exe wins. It clears on any pop or when the FIFO is empty. On reaching STARVE_LIMIT, next state is FORCE.
- **FORCE** (exactly one cycle):
  - exe_stall = 1 and the head is written and popped regardless of exe_wr_en.
  - Counter clears; next state is NORMAL.
- **Writes to x0:** an entry with addr 0 is popped with rd_en = 0 (discarded). exe_wr_en with addr 0 produces rd_en = 0.
- **Scoreboard set:** busy[iss_rd_addr] is set on iss_en when iss_rd_addr ≠ 0.
- **Scoreboard clear:** busy[a] is cleared when a FIFO entry with addr a is popped.
- **Same-cycle set/clear:** on the same address, set wins.
- **Busy outputs:** rs1_busy/rs2_busy = busy_mask[rs*_addr], driven from registered state with no same-cycle clear bypass. The register file is written at the same edge as the clear, so a read the following cycle is correct.
- **Issue-side obligations** (verified by assertion, not handled):
  - No iss_en to a busy register.
  - No exe_wr_en to a busy register.
  - No lsu return for a register that is not busy.

## Timing
- **exe path:** rd_* are combinational from exe_* (zero latency), since the core commits in one cycle.
- **Load path:**
  - Earliest write is the cycle after push. No FIFO fall-through.
  - Busy clears at the clock edge that ends the write cycle.
- **Full/empty:** push while full is impossible (lsu_ready = 0). Pop and push in the same cycle when full is not allowed to relieve lsu_ready in that cycle.
- **Reset values:**
  - FIFO empty, state NORMAL, counter 0, busy_mask 0.
  - lsu_ready 1, exe_stall 0, rs*_busy 0.
  - rd_en forced 0 while rst_n is low; rd_addr 0 and rd_data 0 while rst_n is low.
- **Reset mid-operation:** buffered loads and the scoreboard are discarded immediately. No write is issued.

## Structure
- RV32Consts gains:
  - RegAddr (logic[4:0]).
  - A packed LoadRet struct {RegAddr addr; IntReg data}.
  - A WbState enum {NORMAL, FORCE}.
- One sub-module is natural: wb_fifo, parameterised on depth and carrying LoadRet.
- Arbitration, FSM and scoreboard live in the top module.

## Test plan
- **exe-only write:** exe_wr_en=1, addr 5, data 0xDEADBEEF, FIFO empty → rd_en=1, rd_addr=5, rd_data=0xDEADBEEF same cycle; busy_mask unchanged.
- **Load round trip:** iss_en, addr 7 → busy_mask[7]=1 next cycle. Return 0x12345678 pushed, exe idle → write at push+1, busy_mask[7]=0 after it.
- **Starvation:** FIFO holds 1 entry and exe_wr_en is held high with STARVE_LIMIT=4 → 4 exe writes, then 1 cycle with exe_stall=1 and the FIFO entry written, then exe resumes.
- **Full:** FIFO_DEPTH=2, exe busy, 2 pushes → lsu_ready=0; a further lsu_valid is not accepted; after one pop, lsu_ready=1.
- **x0 and same-cycle set/clear:** return to x0 → popped with rd_en=0. Pop of addr 9 with simultaneous iss_en addr 9 → busy_mask[9] stays 1.
- **Reset mid-operation:** rst_n low with 2 FIFO entries and busy bits set → rd_en=0 immediately, busy_mask=0, lsu_ready=1, no writes after release.
